// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request port.
// Stores commit on acceptance. Loads sample the array on acceptance. Every
// request then waits in an in-order response queue until it has aged LATENCY
// cycles, and is popped when the consumer takes it.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_SIZE    = 1024,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_write,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int PW    = $clog2(QUEUE_DEPTH);
    localparam int CW    = PW + 1;
    localparam int IW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int AGE_W = 3;

    localparam logic [AGE_W-1:0]      AGE_RDY    = AGE_W'(LATENCY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_SIZE);
    localparam logic [CW-1:0]         DEPTH_C    = CW'(QUEUE_DEPTH);

    // Storage array; never reset, so accepted stores survive a reset.
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    // Response queue payload (data, no reset) and per-entry age (control).
    logic                  q_write [QUEUE_DEPTH];
    logic                  q_err   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_rdata [QUEUE_DEPTH];
    logic [AGE_W-1:0]      q_age   [QUEUE_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          in_range;
    logic [IW-1:0] mem_idx;
    logic          push;
    logic          pop;
    logic          head_ready;

    // Age counter that stops once the entry has waited the full latency.
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        if (a >= AGE_RDY)
            return AGE_RDY;
        else
            return a + AGE_W'(1);
    endfunction

    // Handshake decode: ready looks only at registered count, never at resp_ready.
    always_comb begin
        in_range   = (req_addr < ADDR_LIMIT);
        mem_idx    = req_addr[IW-1:0];
        req_ready  = (count < DEPTH_C);
        push       = req_valid && req_ready;
        head_ready = (count != '0) && (q_age[rd_ptr] == AGE_RDY);
        pop        = head_ready && resp_ready;
    end

    // Byte-lane store commit on the acceptance edge; out-of-range stores are dropped.
    always_ff @(posedge clk) begin
        if (push && req_write && in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (req_wstrb[b])
                    mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    // Capture response payload; load data is the array word as of this edge.
    always_ff @(posedge clk) begin
        if (push) begin
            q_write[wr_ptr] <= req_write;
            q_err[wr_ptr]   <= !in_range;
            q_rdata[wr_ptr] <= (!req_write && in_range) ? mem[mem_idx] : '0;
        end
    end

    // Queue pointers and occupancy; reset discards every outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry aging: start at 1 on push, clear on pop, saturate at LATENCY otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                q_age[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (push && (wr_ptr == PW'(i)))
                    q_age[i] <= AGE_W'(1);
                else if (pop && (rd_ptr == PW'(i)))
                    q_age[i] <= '0;
                else if (q_age[i] != '0)
                    q_age[i] <= age_sat_inc(q_age[i]);
            end
        end
    end

    // Response outputs come from the head entry and are forced to zero when not valid.
    always_comb begin
        resp_valid = head_ready;
        resp_rdata = '0;
        resp_write = 1'b0;
        resp_err   = 1'b0;
        busy       = (count != '0);
        if (head_ready) begin
            resp_rdata = q_rdata[rd_ptr];
            resp_write = q_write[rd_ptr];
            resp_err   = q_err[rd_ptr];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (LATENCY 2, depth 4).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_write;
    logic        resp_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_write (resp_write),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
    endtask

    task automatic expect_resp(input string tag, input logic w, input logic e,
                               input logic [31:0] d);
        chk({tag, " valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " write"}, 32'(resp_write), 32'(w));
        chk({tag, " err"},   32'(resp_err),   32'(e));
        chk({tag, " rdata"}, resp_rdata,      d);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, " valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " busy"},  32'(busy),       32'd0);
        chk({tag, " ready"}, 32'(req_ready),  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (2) step();
        chk("rst req_ready",  32'(req_ready),  32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata,      32'd0);
        chk("rst resp_write", 32'(resp_write), 32'd0);
        chk("rst resp_err",   32'(resp_err),   32'd0);
        chk("rst busy",       32'(busy),       32'd0);
        rst = 1'b1;

        // Store then immediate load of the same address
        drive(1, 1, 32'd5, 32'hDEADBEEF, 4'hF);
        step();
        chk("t1 busy after accept", 32'(busy), 32'd1);
        chk("t1 not yet valid", 32'(resp_valid), 32'd0);
        drive(1, 0, 32'd5, 32'd0, 4'h0);
        step();
        expect_resp("t1 store", 1'b1, 1'b0, 32'd0);
        drive(0, 0, 32'd0, 32'd0, 4'h0);
        step();
        expect_resp("t1 load", 1'b0, 1'b0, 32'hDEADBEEF);
        step();
        expect_idle("t1 end");

        // Partial-strobe store merge
        drive(1, 1, 32'd7, 32'h11223344, 4'hF);
        step();
        drive(1, 1, 32'd7, 32'hAABBCCDD, 4'h5);
        step();
        expect_resp("t2 store a", 1'b1, 1'b0, 32'd0);
        drive(1, 0, 32'd7, 32'd0, 4'h0);
        step();
        expect_resp("t2 store b", 1'b1, 1'b0, 32'd0);
        drive(0, 0, 32'd0, 32'd0, 4'h0);
        step();
        expect_resp("t2 load", 1'b0, 1'b0, 32'h11BB33DD);
        step();
        expect_idle("t2 end");

        // Back-to-back: 8 stores to 0..7 then 8 loads of 0..7, no bubbles
        for (int i = 0; i < 16; i++) begin
            if (i < 8)
                drive(1, 1, 32'(i), 32'hA0000000 + 32'(i), 4'hF);
            else
                drive(1, 0, 32'(i - 8), 32'd0, 4'h0);
            chk("t3 req_ready", 32'(req_ready), 32'd1);
            step();
            if (i > 0) begin
                if (i - 1 < 8)
                    expect_resp("t3 store", 1'b1, 1'b0, 32'd0);
                else
                    expect_resp("t3 load", 1'b0, 1'b0, 32'hA0000000 + 32'(i - 9));
            end
        end
        drive(0, 0, 32'd0, 32'd0, 4'h0);
        step();
        expect_resp("t3 load last", 1'b0, 1'b0, 32'hA0000007);
        step();
        expect_idle("t3 end");

        // Back-pressure: fill the queue, hold, then drain
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 32'(k), 32'd0, 4'h0);
            chk("t4 ready while filling", 32'(req_ready), 32'd1);
            step();
        end
        chk("t4 ready full", 32'(req_ready), 32'd0);
        chk("t4 busy full", 32'(busy), 32'd1);
        expect_resp("t4 head", 1'b0, 1'b0, 32'hA0000000);
        drive(1, 0, 32'd4, 32'd0, 4'h0);
        step();
        step();
        chk("t4 ready held", 32'(req_ready), 32'd0);
        expect_resp("t4 head held", 1'b0, 1'b0, 32'hA0000000);
        resp_ready = 1'b1;
        step();
        chk("t4 ready after pop", 32'(req_ready), 32'd1);
        expect_resp("t4 r1", 1'b0, 1'b0, 32'hA0000001);
        step();
        expect_resp("t4 r2", 1'b0, 1'b0, 32'hA0000002);
        chk("t4 ready mid", 32'(req_ready), 32'd1);
        drive(1, 0, 32'd5, 32'd0, 4'h0);
        step();
        expect_resp("t4 r3", 1'b0, 1'b0, 32'hA0000003);
        drive(0, 0, 32'd0, 32'd0, 4'h0);
        step();
        expect_resp("t4 r4", 1'b0, 1'b0, 32'hA0000004);
        step();
        expect_resp("t4 r5", 1'b0, 1'b0, 32'hA0000005);
        step();
        expect_idle("t4 end");

        // Out-of-range load and store
        drive(1, 1, 32'h000003FF, 32'h12345678, 4'hF);
        step();
        drive(1, 0, 32'd1024, 32'd0, 4'h0);
        step();
        expect_resp("t5 store 3ff", 1'b1, 1'b0, 32'd0);
        drive(1, 1, 32'hFFFFFFFF, 32'hBAD0BAD0, 4'hF);
        step();
        expect_resp("t5 load oor", 1'b0, 1'b1, 32'd0);
        drive(1, 0, 32'h000003FF, 32'd0, 4'h0);
        step();
        expect_resp("t5 store oor", 1'b1, 1'b1, 32'd0);
        drive(0, 0, 32'd0, 32'd0, 4'h0);
        step();
        expect_resp("t5 readback", 1'b0, 1'b0, 32'h12345678);
        step();
        expect_idle("t5 end");

        // Reset in flight
        resp_ready = 1'b0;
        drive(1, 0, 32'd1, 32'd0, 4'h0);
        step();
        drive(1, 0, 32'd2, 32'd0, 4'h0);
        step();
        drive(1, 0, 32'd3, 32'd0, 4'h0);
        step();
        drive(0, 0, 32'd0, 32'd0, 4'h0);
        expect_resp("t6 pre-reset head", 1'b0, 1'b0, 32'hA0000001);
        chk("t6 pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6 rst resp_valid", 32'(resp_valid), 32'd0);
        chk("t6 rst busy",       32'(busy),       32'd0);
        chk("t6 rst resp_rdata", resp_rdata,      32'd0);
        chk("t6 rst resp_write", 32'(resp_write), 32'd0);
        chk("t6 rst resp_err",   32'(resp_err),   32'd0);
        step();
        rst = 1'b1;
        resp_ready = 1'b1;
        chk("t6 ready after release", 32'(req_ready), 32'd1);
        step();
        step();
        expect_idle("t6 no stale");
        drive(1, 0, 32'd5, 32'd0, 4'h0);
        step();
        drive(0, 0, 32'd0, 32'd0, 4'h0);
        step();
        expect_resp("t6 readback", 1'b0, 1'b0, 32'hA0000005);
        step();
        expect_idle("t6 end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU's load/store port: it accepts one word request per cycle over a valid/ready handshake, commits stores immediately, and returns in-order responses after a fixed access latency. It sits where the single-cycle data memory sits today, giving the memory stage a realistic multi-cycle, back-pressured target. Outstanding requests are tracked in an internal response queue.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 32, width of the word address.
- MEM_SIZE, 1024, number of words of storage.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..7.
- QUEUE_DEPTH, 4, maximum number of outstanding requests; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address, not a byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_wstrb  in  DATA_WIDTH/8  byte-lane write enables for stores.
- resp_valid  out  1  response present at the queue head.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- resp_write  out  1  response belongs to a store.
- resp_err  out  1  request address was out of range.
- busy  out  1  at least one request is outstanding.

## Operation
- A request is accepted on an edge where req_valid && req_ready.
- req_ready = (count < QUEUE_DEPTH). It depends only on registered count, never on resp_ready, so a full queue refuses a request even in a cycle where the head pops.
- In-range store (req_addr < MEM_SIZE):
  - Each byte lane with its strobe bit set is written on the acceptance edge.
  - Lanes with a 0 strobe keep their old value.
  - req_wstrb = 0 is legal: no change, normal response.
- In-range load: the word is sampled on the acceptance edge, after any earlier store. The sampled value is stored in the queue entry.
- Out-of-range request (req_addr >= MEM_SIZE, full ADDR_WIDTH compare):
  - Stores are dropped and memory is unchanged.
  - Loads return 0.
  - resp_err = 1 in either case.
- Queue entries hold {write, err, rdata, age}. age starts at 1 on acceptance and increments each cycle, saturating at LATENCY.
- resp_valid = (count != 0) && (head age == LATENCY).
- Responses leave strictly in acceptance order. A head-of-line entry that is not yet ready blocks the entries behind it.
- Pop happens on an edge with resp_valid && resp_ready.
- resp_rdata, resp_write and resp_err:
  - Come directly from the head entry while resp_valid = 1.
  - Are driven to 0 while resp_valid = 0.
  - Hold steady under back-pressure until the head pops.
- count is the number of accepted but not yet popped requests. Push and pop in the same cycle leave count unchanged. Read and write pointers wrap modulo QUEUE_DEPTH.
- busy = (count != 0).
- Reset (rst low, at any time, including mid-transaction):
  - Clears the pointers, count and all entry ages.
  - All outstanding requests are discarded, with no response.
  - Memory array contents are not affected by reset.
  - Stores already accepted stay committed.

## Timing
- Reset values: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_write = 0, resp_err = 0, busy = 0.
- Latency: a request accepted at edge N gives resp_valid = 1 in the cycle after edge N+LATENCY-1. With LATENCY = 2, that is the cycle following edge N+1.
- busy rises in the cycle after the acceptance edge.
- Throughput: one request per cycle is sustained with resp_ready held at 1 when QUEUE_DEPTH >= LATENCY + 1. With the defaults there are no bubbles.
- Read-after-write:
  - A load accepted one edge after a store to the same address returns the new data.
  - There is no forwarding path and no hazard window.
- Back-pressure: when resp_ready is low, entries keep aging (saturated). After QUEUE_DEPTH acceptances req_ready drops, and it rises in the cycle after the first pop.
- Deassertion of rst is taken synchronously to clk. The first acceptance is possible on the first rising edge with rst high.

## Test plan
- Reset, then store addr 5 with data 0xDEADBEEF and wstrb 0xF; next cycle load addr 5 -> store response has resp_write = 1, resp_err = 0. Load response has rdata 0xDEADBEEF, arriving LATENCY cycles after its acceptance edge.
- Store 0x11223344 to addr 7, then store 0xAABBCCDD with wstrb 0x5, then load addr 7 -> rdata 0x11BB33DD.
- Back-to-back loads of addrs 0..7 with resp_ready = 1 -> eight responses on consecutive cycles, in order, with req_ready never low.
- Hold resp_ready = 0 and offer 6 requests -> 4 accepted, req_ready = 0 after the 4th. Raise resp_ready -> req_ready = 1 the cycle after the first pop; all 6 responses delivered in order.
- Load addr 1024 and store to addr 0xFFFFFFFF -> both responses have resp_err = 1, rdata = 0, and memory is unchanged (verified by a subsequent in-range readback).
- Accept 3 loads, then assert rst low mid-flight -> resp_valid, busy and all data outputs go to 0 immediately. After release, req_ready = 1, no stale responses appear, and earlier stores remain readable.
